// File: rtl/fir_accumulator.sv
// ---------------------------------------------------------------------------
// fir_accumulator
//
// Purpose:
//   Sums NUM_TAPS unsigned tap products into one output sample. The sum is
//   built with a single adder that adds one buffered tap per clock. The result
//   is clamped to the largest OUT_WIDTH value when it does not fit, and the
//   sample leaves through a valid/ready handshake.
//
// Parameters:
//   DATA_WIDTH - width of each tap product
//   NUM_TAPS   - taps summed per sample (2..16)
//   ACC_WIDTH  - accumulator width; must be >= DATA_WIDTH + clog2(NUM_TAPS)
//                so that the accumulator never wraps
//   OUT_WIDTH  - output sample width; must be <= ACC_WIDTH
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   tap_data   in   NUM_TAPS*DATA_WIDTH, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//   tap_valid  in   tap_data valid
//   tap_ready  out  block accepts tap_data (IDLE only)
//   out_data   out  OUT_WIDTH saturated sum
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data
//   sat_flag   out  the sample currently or last presented was saturated
//   sat_count  out  16-bit saturating count of saturated samples
//
// Configuration macro:
//   FIR_ACC_SAT_STATS_EN - when defined, sat_count is a live counter.
//                          When undefined, sat_count is tied to 0 and no
//                          counter register exists.
//
// Timing (edge E0 accepts a sample):
//   E1..E(NUM_TAPS)  one add per edge
//   E(NUM_TAPS+1)    out_data, sat_flag and out_valid are registered
//   first edge with out_valid && out_ready -> back to IDLE
// ---------------------------------------------------------------------------
module fir_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TAPS   = 4,
  parameter int ACC_WIDTH  = 36,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] tap_data,
  input  logic                           tap_valid,
  output logic                           tap_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sat_flag,
  output logic [15:0]                    sat_count
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int EXT_W = ACC_WIDTH - DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  tap_word  [NUM_TAPS];
  logic [DATA_WIDTH-1:0]  tap_buf_q [NUM_TAPS];
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   acc_d;
  logic [IDX_W-1:0]       idx_q;
  logic [OUT_WIDTH-1:0]   out_data_q;
  logic [OUT_WIDTH-1:0]   out_data_d;
  logic                   out_valid_q;
  logic                   sat_flag_q;
  logic                   sat_d;

  // Unpack the flat tap bus into one word per tap.
  generate
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_unpack
      assign tap_word[gi] = tap_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // One zero-extended tap per cycle. Because of the width rule on
  // ACC_WIDTH, the sum cannot overflow.
  assign acc_d = acc_q + {{EXT_W{1'b0}}, tap_buf_q[idx_q]};

  // The sum saturates when any accumulator bit above the output width is set.
  // If the two widths are equal, the sum always fits.
  generate
    if (ACC_WIDTH > OUT_WIDTH) begin : g_sat_detect
      assign sat_d = |acc_q[ACC_WIDTH-1:OUT_WIDTH];
    end else begin : g_no_sat
      assign sat_d = 1'b0;
    end
  endgenerate

  assign out_data_d = sat_d ? {OUT_WIDTH{1'b1}} : acc_q[OUT_WIDTH-1:0];

`ifdef FIR_ACC_SAT_STATS_EN
  logic [15:0] sat_count_q;
  assign sat_count = sat_count_q;
`else
  assign sat_count = 16'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        tap_buf_q[k] <= '0;
      end
`ifdef FIR_ACC_SAT_STATS_EN
      sat_count_q <= 16'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (tap_valid) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
              tap_buf_q[k] <= tap_word[k];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ACCUM;
          end
        end

        ACCUM: begin
          acc_q <= acc_d;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= OUTPUT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end

        OUTPUT: begin
          // The first cycle in OUTPUT registers the clamped result from the
          // completed accumulator. Later cycles hold it until the handshake.
          if (!out_valid_q) begin
            out_data_q  <= out_data_d;
            sat_flag_q  <= sat_d;
            out_valid_q <= 1'b1;
`ifdef FIR_ACC_SAT_STATS_EN
            if (sat_d && (sat_count_q != 16'hFFFF)) begin
              sat_count_q <= sat_count_q + 16'd1;
            end
`endif
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tap_ready = (state_q == IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_flag_q;

endmodule
